// File: rtl/ab_debouncer_pkg.sv
// Shared constants for the two-input switch debouncer and its bench.
package ab_debouncer_pkg;

  // Stability window used on hardware (1 ms at 50 MHz).
  localparam int DEB_STABLE_HW  = 50000;
  // Short stability window so simulations stay fast.
  localparam int DEB_STABLE_SIM = 4;
  // Width of each per-channel stability counter.
  localparam int DEB_CNT_W      = 16;

  // Identifies which of the two channels a signal belongs to.
  typedef enum logic {
    DEB_CH_A = 1'b0,
    DEB_CH_B = 1'b1
  } deb_chan_e;

endpackage

// File: rtl/ab_debouncer_if.sv
// Raw inputs and conditioned outputs of the two-channel debouncer.
interface ab_debouncer_if;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  // Switch side: drives the raw levels and consumes the clean ones.
  modport master (
    output a_raw, b_raw,
    input  a, b, a_rise, a_fall, b_rise, b_fall
  );

  // Debouncer side: consumes raw levels and drives clean levels and pulses.
  modport slave (
    input  a_raw, b_raw,
    output a, b, a_rise, a_fall, b_rise, b_fall
  );
endinterface

// File: rtl/ab_debouncer_debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter,
// registered clean level and one-cycle rise/fall pulses.
module debounce_chan
  import ab_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_HW,
  parameter int CNT_W         = DEB_CNT_W
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: count consecutive disagreeing samples, flip the level
  // once the disagreement has lasted the full window.
  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; clr clears everything including a count in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ab_debouncer.sv
// Two independent debounce channels conditioning switch inputs A and B
// for the downstream decoder.
module ab_debouncer
  import ab_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_HW,
  parameter int CNT_W         = DEB_CNT_W
) (
  input  logic           clk,
  input  logic           clr,
  ab_debouncer_if.slave  bus
);

  debounce_chan #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .clr   (clr),
    .raw   (bus.a_raw),
    .level (bus.a),
    .rise  (bus.a_rise),
    .fall  (bus.a_fall)
  );

  debounce_chan #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .clr   (clr),
    .raw   (bus.b_raw),
    .level (bus.b),
    .rise  (bus.b_rise),
    .fall  (bus.b_fall)
  );

endmodule

// File: tb/tb_ab_debouncer.sv
// Directed and random bench for ab_debouncer against a window-based model:
// a level flips when the last N synchronised samples since the previous
// flip/reset all disagree with it.
module tb_ab_debouncer;
  import ab_debouncer_pkg::*;

  localparam int N    = DEB_STABLE_SIM;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic clr = 1'b1;

  ab_debouncer_if ifc ();

  ab_debouncer #(
    .STABLE_CYCLES (N),
    .CNT_W         (DEB_CNT_W)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state.
  int   k = 0;
  logic hist [2][HMAX];
  int   last_evt [2];
  logic m_lvl [2];
  logic m_rise [2];
  logic m_fall [2];
  logic m_d1 [2];
  logic m_d2 [2];

  // Per-segment observations of DUT pulses.
  int seg_edge;
  int n_ar, n_af, n_br, n_bf;
  int ar_edge, af_edge, br_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge(input logic ra, input logic rb, input logic c);
    logic rw [2];
    logic sync;
    bit   ok;
    rw[0] = ra;
    rw[1] = rb;
    k++;
    for (int ch = 0; ch < 2; ch++) begin
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      if (c) begin
        m_lvl[ch]    = 1'b0;
        m_d1[ch]     = 1'b0;
        m_d2[ch]     = 1'b0;
        last_evt[ch] = k;
      end else begin
        sync          = m_d2[ch];
        m_d2[ch]      = m_d1[ch];
        m_d1[ch]      = rw[ch];
        hist[ch][k]   = sync;
        ok = ((k - last_evt[ch]) >= N);
        if (ok) begin
          for (int j = 0; j < N; j++)
            if (hist[ch][k-j] == m_lvl[ch]) ok = 1'b0;
        end
        if (ok) begin
          m_lvl[ch]    = ~m_lvl[ch];
          m_rise[ch]   = m_lvl[ch];
          m_fall[ch]   = ~m_lvl[ch];
          last_evt[ch] = k;
        end
      end
    end
  endtask

  task automatic seg_start();
    seg_edge = 0;
    n_ar = 0; n_af = 0; n_br = 0; n_bf = 0;
    ar_edge = -1; af_edge = -1; br_edge = -1;
  endtask

  task automatic step(input logic ra, input logic rb, input logic c);
    @(negedge clk);
    ifc.a_raw = ra;
    ifc.b_raw = rb;
    clr       = c;
    @(posedge clk);
    model_edge(ra, rb, c);
    #1;
    seg_edge++;
    chk("a",      ifc.a,      m_lvl[0]);
    chk("b",      ifc.b,      m_lvl[1]);
    chk("a_rise", ifc.a_rise, m_rise[0]);
    chk("a_fall", ifc.a_fall, m_fall[0]);
    chk("b_rise", ifc.b_rise, m_rise[1]);
    chk("b_fall", ifc.b_fall, m_fall[1]);
    if (ifc.a_rise === 1'b1) begin n_ar++; ar_edge = seg_edge; end
    if (ifc.a_fall === 1'b1) begin n_af++; af_edge = seg_edge; end
    if (ifc.b_rise === 1'b1) begin n_br++; br_edge = seg_edge; end
    if (ifc.b_fall === 1'b1) n_bf++;
  endtask

  task automatic hold(input logic ra, input logic rb, input int cycles);
    for (int i = 0; i < cycles; i++) step(ra, rb, 1'b0);
  endtask

  // Watchdog: the run is a few hundred cycles; this only fires on a hang.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.a_raw = 1'b1;
    ifc.b_raw = 1'b1;

    // 1. Reset with raw held high, then release.
    seg_start();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("reset_a", ifc.a, 1'b0);
      chk("reset_b", ifc.b, 1'b0);
    end
    seg_start();
    hold(1'b1, 1'b1, N + 3);
    chk("rel_a_rise_edge", ar_edge, N + 2);
    chk("rel_b_rise_edge", br_edge, N + 2);
    chk("rel_a_rise_cnt",  n_ar, 1);
    chk("rel_b_rise_cnt",  n_br, 1);
    hold(1'b0, 1'b0, 10);

    // 2. Glitch shorter than the window.
    seg_start();
    hold(1'b1, 1'b0, N - 1);
    hold(1'b0, 1'b0, 10);
    chk("glitch_a_rise_cnt", n_ar, 0);
    chk("glitch_a", ifc.a, 1'b0);
    chk("glitch_b_pulses", n_br + n_bf, 0);

    // 3. Clean press then release.
    seg_start();
    hold(1'b1, 1'b0, 12);
    chk("press_rise_edge", ar_edge, N + 2);
    chk("press_rise_cnt",  n_ar, 1);
    seg_start();
    hold(1'b0, 1'b0, 12);
    chk("release_fall_edge", af_edge, N + 2);
    chk("release_fall_cnt",  n_af, 1);
    chk("release_rise_cnt",  n_ar, 0);

    // 4. Bounce then settle high.
    seg_start();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 12);
    chk("bounce_rise_edge", ar_edge, 4 + N + 2);
    chk("bounce_rise_cnt",  n_ar, 1);
    chk("bounce_fall_cnt",  n_af, 0);
    hold(1'b0, 1'b0, 10);

    // 5. Simultaneous rise on both channels.
    seg_start();
    hold(1'b1, 1'b1, 10);
    chk("simul_a_edge", ar_edge, N + 2);
    chk("simul_b_edge", br_edge, N + 2);
    hold(1'b0, 1'b0, 10);

    // 6. Reset in the middle of a count.
    seg_start();
    hold(1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 1'b1);
    chk("midclr_a", ifc.a, 1'b0);
    seg_start();
    hold(1'b1, 1'b0, 10);
    chk("midclr_rise_edge", ar_edge, N + 2);
    chk("midclr_rise_cnt",  n_ar, 1);

    // Random segments, including short bouncy runs and rare resets.
    for (int s = 0; s < 60; s++) begin
      logic ra, rb, c;
      int   len;
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      c   = ($urandom_range(0, 24) == 0);
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) step(ra, rb, (j == 0) ? c : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
